mux_rr_arbiter: RTL
===================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for the 8:1 bit mux: 8 requesters share one serial output bit.
//  Picks a winner, drives the 3-bit select of an internal EightToOneMux, and forwards the winner's
//  data bit over a valid/ready handshake. Holds a grant for at most HOLD_MAX beats.
//  Sits between the CAM match-line sources and the single downstream validation checker port.
// PARAMETERS
//  N_REQ     8  number of requesters; fixed by mux width, not overridable
//  SEL_W     3  select width, $clog2(N_REQ)
//  HOLD_MAX  4  max accepted beats per grant before a forced release; legal range 1..15
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   8      request per requester; must stay high until its data is accepted
//  data_in    in   8      one data bit per requester; routed through the mux
//  out_ready  in   1      downstream accepts out_data when out_valid & out_ready
//  grant      out  8      one-hot grant, registered; all zero when idle
//  sel        out  3      registered mux select = index of granted requester
//  out_valid  out  1      registered; high while in GRANT state
//  out_data   out  1      data_in[sel], combinational from the mux
//  beat_cnt   out  4      accepted beats in the current grant
// BEHAVIOUR
//  Reset (async on rst_n low): state=IDLE, grant=0, sel=0, out_valid=0, beat_cnt=0, last_ptr=7
//   (requester 0 has top priority after reset). out_data follows data_in[0].
//  FSM: IDLE, GRANT.
//   IDLE: if |req, winner = first set bit scanning last_ptr+1, last_ptr+2, ... mod 8;
//    next cycle: GRANT, grant=onehot(winner), sel=winner, last_ptr=winner, beat_cnt=0.
//    No req: stay IDLE. Latency req -> out_valid: 1 cycle.
//   GRANT: out_valid=1. Transfer = out_valid & out_ready; each transfer increments beat_cnt.
//    Release (-> IDLE next cycle, grant=0, out_valid=0, beat_cnt=0) when:
//     a) transfer and beat_cnt+1 == HOLD_MAX (forced release), or
//     b) transfer and req[sel]==0 in the same cycle (final beat), or
//     c) req[sel]==0 with no transfer (abort; beat not counted).
//    Otherwise stay in GRANT; sel and grant must not change while in GRANT.
//  Every release costs one IDLE bubble cycle; re-arbitration happens only in IDLE.
//  last_ptr only updates on grant; a released requester goes to lowest priority.
//   Requests from other requesters during GRANT are ignored until IDLE.
//  Wrap-around: scan from last_ptr=7 starts at 0; a single requester regains grant every
//   other cycle (GRANT, IDLE, GRANT, ...).
//  beat_cnt is 4 bits; never exceeds HOLD_MAX-1 while visible in GRANT.
//  out_ready low holds the beat indefinitely; no timeout.
//  rst_n asserted mid-grant: outputs clear immediately; no transfer is counted in that cycle.
//  out_ready is ignored in IDLE.
//  Invariant: $onehot0(grant); grant!=0 iff out_valid; grant==(1<<sel) when out_valid.
// STRUCTURE
//  Package mux_arb_pkg: typedef enum logic {IDLE, GRANT} arb_state_t; localparams N_REQ=8, SEL_W=3.
//  Sub-module rr_pick8: combinational (req[7:0], last_ptr[2:0]) -> (any, idx[2:0]);
//   rotate, priority-encode, un-rotate.
//  Datapath: one EightToOneMux instance (input_lines=data_in, selector_bits=sel,
//   output_line=out_data).
//  Top: state/grant/sel/beat_cnt/last_ptr flops in one always_ff with async reset;
//   next-state logic in always_comb.
// TESTING
//  1 Reset then req=8'b0000_0001, out_ready=1 -> grant=0x01 at +1 cycle;
//    data_in[0] seen on out_data; drop req with beat 2 -> IDLE.
//  2 req=8'hFF held, out_ready=1, HOLD_MAX=4 -> grants 0,1,2,...,7,0 in order;
//    each exactly 4 beats; one IDLE cycle between grants.
//  3 last_ptr=5, req=8'b0010_0001 -> grant requester 0 (wrap past 7).
//    Next arbitration with same req -> requester 5.
//  4 Grant 3 with out_ready=0 for 10 cycles -> out_valid held, beat_cnt=0, sel=3 stable.
//    Then deassert req[3] -> abort to IDLE, no beat counted.
//  5 Mid-GRANT (beat_cnt=2) pulse rst_n low -> grant=0 and out_valid=0 asynchronously.
//    After release, req=0x80 -> requester 7 granted (last_ptr back to 7, scan from 0).
//  6 Random req/out_ready for 10k cycles -> onehot0/sel assertions hold.
//    No requester starves beyond 7 grants.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin 8:1 bit-mux arbiter.
// The requester count is tied to the mux width, so these values are fixed.
package mux_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [N_REQ-1:0] onehot_of(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/EightToOneMux.sv
// Plain 8:1 single-bit multiplexer used for the shared serial output bit.
module EightToOneMux
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] input_lines,
  input  logic [SEL_W-1:0] selector_bits,
  output logic             output_line
);
  assign output_line = input_lines[selector_bits];
endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: the scan starts just after last_ptr and wraps.
// The request vector is rotated, priority-encoded, then the offset is un-rotated.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] start;
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  assign start = last_ptr + SEL_W'(1);

  // rot[0] is the requester with the highest priority this round
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot[gi] = req[start + SEL_W'(gi)];
  end

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign any = |req;
  assign idx = off + start;
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one serial bit over valid/ready.
// A grant lasts at most HOLD_MAX accepted beats; each release costs one idle cycle.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  input  logic             out_ready,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             out_data,
  output logic [3:0]       beat_cnt
);
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_ptr_q, last_ptr_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             xfer;
  logic             release_now;

  rr_pick8 u_pick (
    .req      (req),
    .last_ptr (last_ptr_q),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  EightToOneMux u_mux (
    .input_lines   (data_in),
    .selector_bits (sel_q),
    .output_line   (out_data)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    last_ptr_d  = last_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    xfer        = out_valid_q & out_ready;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          grant_d     = onehot_of(pick_idx);
          sel_d       = pick_idx;
          last_ptr_d  = pick_idx;
          beat_cnt_d  = '0;
          out_valid_d = 1'b1;
        end
      end
      GRANT: begin
        // A dropped request ends the grant whether or not a beat moved this cycle
        if (xfer) release_now = (beat_cnt_q + 4'd1 == HOLD_LIM) || !req[sel_q];
        else      release_now = !req[sel_q];
        if (release_now) begin
          state_d     = IDLE;
          grant_d     = '0;
          beat_cnt_d  = '0;
          out_valid_d = 1'b0;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      last_ptr_q  <= SEL_W'(N_REQ - 1);
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      last_ptr_q  <= last_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign beat_cnt  = beat_cnt_q;
endmodule
